snake_pipe: RTL and testbench

Parametrised, handshaked successor to the fixed snake netlists. One input word fans out into `LANES` parallel lanes. Each lane rotates the word by its lane index and carries it through `DEPTH` register stages. All lanes then reconverge through a registered reduction stage onto a single output stream. The block sits between a valid/ready producer and consumer, and serves as the sequential, backpressured reference block for the schematic and debug test designs.

---
 rtl/snake_pipe_pkg.sv | 30 +++
 rtl/snake_pipe_if.sv | 29 ++
 rtl/snake_pipe_lane.sv | 35 +++
 rtl/snake_pipe.sv | 121 ++++++++++++
 tb/tb_snake_pipe.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pipe_pkg.sv
// snake_pkg: reduction mode encodings and the lane rotation helper shared by
// the snake_pipe top level, its lanes and the testbench.
package snake_pkg;

    // Reduction modes, sampled with the input word and carried with the token
    localparam logic [1:0] SNAKE_XOR = 2'd0;
    localparam logic [1:0] SNAKE_SUM = 2'd1;
    localparam logic [1:0] SNAKE_OR  = 2'd2;
    localparam logic [1:0] SNAKE_AND = 2'd3;

    // Widest word rotl can handle; callers zero-extend into and truncate out of it
    localparam int ROTL_MAX_WIDTH = 64;

    // Rotate the low 'width' bits of 'value' left by 'shift' places, modulo width
    function automatic logic [ROTL_MAX_WIDTH-1:0] rotl(
        input logic [ROTL_MAX_WIDTH-1:0] value,
        input int                        width,
        input int                        shift
    );
        logic [ROTL_MAX_WIDTH-1:0] result;
        result = '0;
        for (int b = 0; b < ROTL_MAX_WIDTH; b++) begin
            if (b < width) begin
                result[(b + shift) % width] = value[b];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/snake_pipe_if.sv
// snake_pipe_if: producer-side and consumer-side valid/ready streams of
// snake_pipe plus its handshake counter, bundled for a single port.
interface snake_pipe_if #(
    parameter int WIDTH = 8
);
    import snake_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [15:0]      out_count;

    // Environment side: produces input words, consumes results
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    // Block side: accepts input words, presents results
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

endinterface

// File: rtl/snake_pipe_lane.sv
// snake_lane: data register chain for one lane. The word is rotated by SHIFT
// on entry and then shifted through DEPTH stages. Stage enables come from the
// top level so every lane moves in lockstep with the shared valid chain.
module snake_lane
    import snake_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] i_data,
    input  logic [DEPTH-1:0] i_load,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] r_stage [DEPTH];

    assign w_rot  = WIDTH'(rotl(ROTL_MAX_WIDTH'(i_data), WIDTH, SHIFT));
    assign o_data = r_stage[DEPTH-1];

    // Data only moves when its stage is loaded; validity lives in the top level
    always_ff @(posedge clk) begin
        if (i_load[0]) begin
            r_stage[0] <= w_rot;
        end
        for (int n = 1; n < DEPTH; n++) begin
            if (i_load[n]) begin
                r_stage[n] <= r_stage[n-1];
            end
        end
    end

endmodule

// File: rtl/snake_pipe.sv
// snake_pipe: one input word fans out into LANES rotated copies, each carried
// through DEPTH register stages, then reduced (XOR/SUM/OR/AND, chosen per
// token) into a registered output stage. Fully backpressured valid/ready
// pipeline with a wrapping count of completed output handshakes.
module snake_pipe
    import snake_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    snake_pipe_if.slave  bus
);

    // Index 0..DEPTH-1 are the lane stages, index DEPTH is the output stage
    logic [DEPTH:0]   r_valid;
    logic [DEPTH:0]   w_adv;
    logic [DEPTH:0]   w_load;
    logic [1:0]       r_mode [DEPTH];
    logic [WIDTH-1:0] w_lane [LANES];
    logic [WIDTH-1:0] w_reduce;
    logic [WIDTH-1:0] r_out_data;
    logic [15:0]      r_count;
    logic             w_in_ready;
    logic             w_accept;

    // A stage advances when it holds a token and the next stage is free or moving
    always_comb begin
        logic [DEPTH:0] adv;
        adv        = '0;
        adv[DEPTH] = r_valid[DEPTH] && bus.out_ready;
        for (int n = DEPTH - 1; n >= 0; n--) begin
            adv[n] = r_valid[n] && (!r_valid[n+1] || adv[n+1]);
        end
        w_adv = adv;
    end

    assign w_in_ready = !rst && (!r_valid[0] || w_adv[0]);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_load     = {w_adv[DEPTH-1:0], w_accept};

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid[DEPTH];
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_count;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        snake_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .SHIFT (g)
        ) u_lane (
            .clk    (clk),
            .i_data (bus.in_data),
            .i_load (w_load[DEPTH-1:0]),
            .o_data (w_lane[g])
        );
    end

    // Mode travels alongside the lane data so a later mode change cannot touch it
    always_ff @(posedge clk) begin
        if (w_load[0]) begin
            r_mode[0] <= bus.in_mode;
        end
        for (int n = 1; n < DEPTH; n++) begin
            if (w_load[n]) begin
                r_mode[n] <= r_mode[n-1];
            end
        end
    end

    // Combine all lane outputs using the mode that arrived with this token
    always_comb begin
        logic [WIDTH-1:0] accXor;
        logic [WIDTH-1:0] accSum;
        logic [WIDTH-1:0] accOr;
        logic [WIDTH-1:0] accAnd;
        accXor = '0;
        accSum = '0;
        accOr  = '0;
        accAnd = '1;
        for (int l = 0; l < LANES; l++) begin
            accXor = accXor ^ w_lane[l];
            accSum = accSum + w_lane[l];
            accOr  = accOr | w_lane[l];
            accAnd = accAnd & w_lane[l];
        end
        w_reduce = accXor;
        case (r_mode[DEPTH-1])
            SNAKE_XOR: w_reduce = accXor;
            SNAKE_SUM: w_reduce = accSum;
            SNAKE_OR:  w_reduce = accOr;
            SNAKE_AND: w_reduce = accAnd;
        endcase
    end

    // Valid chain and handshake counter; reset drops every in-flight token
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_load | (r_valid & ~w_adv);
            if (w_adv[DEPTH]) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    // Output data register only changes when a new result moves in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (w_load[DEPTH]) begin
            r_out_data <= w_reduce;
        end
    end

endmodule

// File: tb/tb_snake_pipe.sv
// tb_snake_pipe: directed vectors for snake_pipe with a queue scoreboard.
// Stimulus pushes hand-computed results; an independent monitor pops and
// compares on every output handshake.
module tb_snake_pipe;
    import snake_pkg::*;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    snake_pipe_if #(.WIDTH(WIDTH)) bus ();

    snake_pipe #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    logic [WIDTH-1:0] expQueue [$];
    logic [15:0]      expCount    = '0;
    logic             prevStalled = 1'b0;
    logic [WIDTH-1:0] prevData    = '0;

    // Counts rising edges so throughput can be measured
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFailure(input string name, input string detail);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: %s at %0t", name, detail, $time);
    endtask

    task automatic scoreHandshake();
        checkOutput("count_at_handshake", 32'(bus.out_count), 32'(expCount));
        if (expQueue.size() == 0) begin
            reportFailure("unexpected_output", $sformatf("got 0x%0h, required no token", bus.out_data));
        end else begin
            checkOutput("out_data", 32'(bus.out_data), 32'(expQueue.pop_front()));
        end
    endtask

    // Monitor: compares each emitted word and checks stall stability
    always @(negedge clk) begin
        if (rst) begin
            expQueue.delete();
            expCount    <= '0;
            prevStalled <= 1'b0;
        end else begin
            if (bus.out_valid && prevStalled) begin
                checkOutput("hold_stable", 32'(bus.out_data), 32'(prevData));
            end
            if (bus.out_valid && bus.out_ready) begin
                scoreHandshake();
                expCount <= expCount + 16'd1;
            end
            prevStalled <= bus.out_valid && !bus.out_ready;
            prevData    <= bus.out_data;
        end
    end

    // Drive one token and hold it until accepted; returns 1 ns after the accepting edge
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode,
                                 input logic [7:0] expected);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_mode  = mode;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                expQueue.push_back(expected);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        reportFailure("accept_timeout", "in_ready never rose");
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic applyReset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitDrain();
        for (int w = 0; w < 40; w++) begin
            @(posedge clk);
            #1;
            if (expQueue.size() == 0 && !bus.out_valid) return;
        end
        reportFailure("drain_timeout", $sformatf("%0d tokens still expected", expQueue.size()));
    endtask

    logic [7:0] sData [8] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
    logic [1:0] sMode [8] = '{SNAKE_XOR, SNAKE_SUM, SNAKE_OR, SNAKE_AND,
                              SNAKE_XOR, SNAKE_SUM, SNAKE_OR, SNAKE_AND};
    logic [7:0] sExp  [8] = '{8'h88, 8'h96, 8'h8F, 8'h00, 8'h55, 8'h1B, 8'hF7, 8'h80};

    logic [7:0] bpData [4] = '{8'h81, 8'hF0, 8'h01, 8'hF0};
    logic [1:0] bpMode [4] = '{SNAKE_XOR, SNAKE_SUM, SNAKE_OR, SNAKE_AND};
    logic [7:0] bpExp  [4] = '{8'h88, 8'h1B, 8'h0F, 8'h80};

    // Watchdog so the run always ends
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startCycle;
        int idx;
        int accepted;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = SNAKE_XOR;
        bus.out_ready = 1'b1;

        // Reset values and in_ready behaviour around reset release
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ready_in_reset", 32'(bus.in_ready), 0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 0);
        checkOutput("reset_out_count", 32'(bus.out_count), 0);
        checkOutput("reset_out_data", 32'(bus.out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Single tokens at every mode with latency check
        $display("[TB] single tokens");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(sData[i], sMode[i], sExp[i]);
            idle();
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("latency_early", 32'(bus.out_valid), 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("latency_due", 32'(bus.out_valid), 1);
            @(posedge clk);
            #1;
        end
        waitDrain();

        // Streaming at full rate
        $display("[TB] streaming");
        applyReset();
        startCycle = cycle;
        for (int i = 0; i < 10; i++) applyStimulus(8'h01, SNAKE_XOR, 8'h0F);
        checkOutput("stream_throughput", 32'(cycle - startCycle), 10);
        idle();
        waitDrain();
        checkOutput("stream_count", 32'(bus.out_count), 10);

        // Backpressure fill, simultaneous accept/emit, gapless drain
        $display("[TB] backpressure");
        applyReset();
        bus.out_ready = 1'b0;
        idx           = 0;
        accepted      = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = bpData[0];
        bus.in_mode   = bpMode[0];
        repeat (6) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted++;
                if (idx < 4) begin
                    expQueue.push_back(bpExp[idx]);
                    idx++;
                end
            end
            @(posedge clk);
            #1;
            if (idx < 4) begin
                bus.in_data = bpData[idx];
                bus.in_mode = bpMode[idx];
            end
        end
        checkOutput("bp_accepts", 32'(accepted), 3);
        @(negedge clk);
        checkOutput("bp_full_ready", 32'(bus.in_ready), 0);
        checkOutput("bp_head", 32'(bus.out_data), 32'h88);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_simul_ready", 32'(bus.in_ready), 1);
        if (bus.in_ready && idx < 4) expQueue.push_back(bpExp[idx]);
        @(posedge clk);
        #1;
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_no_gap", 32'(bus.out_valid), 1);
            @(posedge clk);
            #1;
        end
        waitDrain();

        // Mode change while the previous token is in flight
        $display("[TB] mode change in flight");
        applyStimulus(8'h81, SNAKE_SUM, 8'h96);
        applyStimulus(8'h81, SNAKE_XOR, 8'h88);
        idle();
        waitDrain();

        // Reset with tokens in flight
        $display("[TB] reset mid-operation");
        applyReset();
        for (int i = 0; i < 5; i++) applyStimulus(8'hF0, SNAKE_OR, 8'hF7);
        idle();
        waitDrain();
        checkOutput("pre_reset_count", 32'(bus.out_count), 5);
        bus.out_ready = 1'b0;
        applyStimulus(8'h81, SNAKE_XOR, 8'h88);
        applyStimulus(8'h81, SNAKE_XOR, 8'h88);
        idle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_during_reset", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_valid", 32'(bus.out_valid), 0);
        checkOutput("post_reset_count", 32'(bus.out_count), 0);
        checkOutput("post_reset_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        checkOutput("no_stale_count", 32'(bus.out_count), 0);

        // Counter wrap after 65536 handshakes
        $display("[TB] counter wrap");
        applyReset();
        for (int i = 0; i < 65536; i++) applyStimulus(8'h81, SNAKE_OR, 8'h8F);
        idle();
        waitDrain();
        checkOutput("wrap_count", 32'(bus.out_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
